// File: rtl/systolic_feeder.sv
// Operand feeder for the 3x3 systolic multiplier: stores A and B, then replays them
// as diagonally skewed row/column streams framed by an array clear and a done pulse.
module systolic_feeder #(
    parameter int DATA_W       = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  load_sel,
    input  logic [1:0]            load_row,
    input  logic [3*DATA_W-1:0]   load_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  array_clr,
    output logic [DATA_W-1:0]     a1,
    output logic [DATA_W-1:0]     a2,
    output logic [DATA_W-1:0]     a3,
    output logic [DATA_W-1:0]     b1,
    output logic [DATA_W-1:0]     b2,
    output logic [DATA_W-1:0]     b3
);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        step_reg;
    logic [7:0]        drain_reg;
    logic              busy_reg;
    logic              ready_reg;
    logic              done_reg;
    logic              clr_reg;

    logic [DATA_W-1:0] a_mem [3][3];
    logic [DATA_W-1:0] b_mem [3][3];
    logic [DATA_W-1:0] a_reg [3];
    logic [DATA_W-1:0] b_reg [3];
    logic [DATA_W-1:0] a_next [3];
    logic [DATA_W-1:0] b_next [3];

    // Row write port; row index 3 is a legal no-op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (load_valid && ready_reg && load_row != 2'd3) begin
            for (int c = 0; c < 3; c++) begin
                if (load_sel)
                    b_mem[load_row][c] <= load_data[c*DATA_W +: DATA_W];
                else
                    a_mem[load_row][c] <= load_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Lane gi lags lane 0 by gi steps, producing the diagonal skew.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [2:0] diff;
        logic       hit;
        assign diff       = step_reg - 3'(gi);
        assign hit        = (state_reg == STREAM) && (step_reg >= 3'(gi)) && (diff <= 3'd2);
        assign a_next[gi] = hit ? a_mem[gi][diff[1:0]] : '0;
        assign b_next[gi] = hit ? b_mem[diff[1:0]][gi] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            step_reg  <= '0;
            drain_reg <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            clr_reg   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            clr_reg  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_reg[i] <= a_next[i];
                b_reg[i] <= b_next[i];
            end
            // Each state decides what the outputs show after the next edge,
            // so busy covers the done cycle before dropping.
            case (state_reg)
                IDLE: begin
                    busy_reg  <= start;
                    ready_reg <= !start;
                    if (start)
                        state_reg <= CLR;
                end
                CLR: begin
                    clr_reg   <= 1'b1;
                    step_reg  <= '0;
                    state_reg <= STREAM;
                end
                STREAM: begin
                    step_reg <= step_reg + 3'd1;
                    if (step_reg == 3'd4) begin
                        drain_reg <= '0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_reg <= drain_reg + 8'd1;
                    if (drain_reg == 8'(DRAIN_CYCLES - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign load_ready = ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign array_clr  = clr_reg;
    assign a1         = a_reg[0];
    assign a2         = a_reg[1];
    assign a3         = a_reg[2];
    assign b1         = b_reg[0];
    assign b2         = b_reg[1];
    assign b3         = b_reg[2];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: checks every output on every cycle of each
// feed sequence against hand-computed skewed streams.
module tb_systolic_feeder;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [1:0]  load_row;
    logic [23:0] load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        array_clr;
    logic [7:0]  a1, a2, a3, b1, b2, b3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_a [5];
    logic [23:0] exp_b [5];

    systolic_feeder #(.DATA_W(8), .DRAIN_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_row   (load_row),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .array_clr  (array_clr),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .b1         (b1),
        .b2         (b2),
        .b3         (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic clr, input logic dn, input logic bsy,
                                       input logic rdy, input logic [23:0] a, input logic [23:0] b);
        return {12'd0, clr, dn, bsy, rdy, a, b};
    endfunction

    function automatic logic [63:0] obs();
        return pk(array_clr, done, busy, load_ready, {a1, a2, a3}, {b1, b2, b3});
    endfunction

    task automatic chk(input string tag, input int idx, input logic [63:0] o, input logic [63:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed clr/done/busy/rdy/a/b=%h expected %h", tag, idx, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [1:0] row,
                        input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = row;
        load_data  = {c2, c1, c0};
        tick();
        load_valid = 1'b0;
    endtask

    // Full sequence from the start edge to the return to IDLE, one check per cycle.
    task automatic run_seq(input string tag, input bit disturb);
        start = 1'b1;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        chk(tag, 0, obs(), pk(0, 0, 1, 0, 24'd0, 24'd0));
        tick();
        chk(tag, 1, obs(), pk(1, 0, 1, 0, 24'd0, 24'd0));
        if (disturb) begin
            start      = 1'b1;
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_row   = 2'd0;
            load_data  = 24'hFFFFFF;
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            chk(tag, 2 + t, obs(), pk(0, 0, 1, 0, exp_a[t], exp_b[t]));
        end
        for (int d = 0; d < 8; d++) begin
            tick();
            chk(tag, 7 + d, obs(), pk(0, 0, 1, 0, 24'd0, 24'd0));
            if (d == 6) begin
                start      = 1'b0;
                load_valid = 1'b0;
            end
        end
        tick();
        chk(tag, 15, obs(), pk(0, 1, 1, 0, 24'd0, 24'd0));
        tick();
        chk(tag, 16, obs(), pk(0, 0, 0, 1, 24'd0, 24'd0));
    endtask

    task automatic set_nominal();
        exp_a[0] = {8'd3,  8'd0, 8'd0}; exp_b[0] = {8'd7,  8'd0, 8'd0};
        exp_a[1] = {8'd12, 8'd5, 8'd0}; exp_b[1] = {8'd11, 8'd3, 8'd0};
        exp_a[2] = {8'd4,  8'd6, 8'd1}; exp_b[2] = {8'd6,  8'd9, 8'd8};
        exp_a[3] = {8'd0,  8'd8, 8'd0}; exp_b[3] = {8'd0,  8'd8, 8'd5};
        exp_a[4] = {8'd0,  8'd0, 8'd2}; exp_b[4] = {8'd0,  8'd0, 8'd4};
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_row   = 2'd0;
        load_data  = 24'd0;
        start      = 1'b0;
        tick();
        tick();
        chk("in_reset", 0, pk(array_clr, done, busy, 1'b0, {a1, a2, a3}, {b1, b2, b3}),
            pk(0, 0, 0, 0, 24'd0, 24'd0));
        reset = 1'b1;
        tick();
        chk("after_reset", 0, obs(), pk(0, 0, 0, 1, 24'd0, 24'd0));

        load(1'b0, 2'd0, 8'd3, 8'd12, 8'd4);
        load(1'b0, 2'd1, 8'd5, 8'd6,  8'd8);
        load(1'b0, 2'd2, 8'd1, 8'd0,  8'd2);
        load(1'b1, 2'd0, 8'd7, 8'd3,  8'd8);
        load(1'b1, 2'd1, 8'd11, 8'd9, 8'd5);
        load(1'b1, 2'd2, 8'd6, 8'd8,  8'd4);

        set_nominal();
        run_seq("run_nominal", 1'b0);
        run_seq("run_disturbed", 1'b1);

        load(1'b0, 2'd3, 8'd255, 8'd255, 8'd255);
        load(1'b1, 2'd3, 8'd255, 8'd255, 8'd255);
        run_seq("run_after_row3", 1'b0);

        // A row0 rewritten on the very edge that samples start.
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_row   = 2'd0;
        load_data  = {8'd9, 8'd9, 8'd9};
        exp_a[0] = {8'd9, 8'd0, 8'd0};
        exp_a[1] = {8'd9, 8'd5, 8'd0};
        exp_a[2] = {8'd9, 8'd6, 8'd1};
        run_seq("run_load_with_start", 1'b0);

        // Reset in the middle of stream step t2.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_abort_t2", 0, obs(), pk(0, 0, 1, 0, exp_a[2], exp_b[2]));
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 0, pk(array_clr, done, busy, 1'b0, {a1, a2, a3}, {b1, b2, b3}),
            pk(0, 0, 0, 0, 24'd0, 24'd0));
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("idle_no_done", i, obs(), pk(0, 0, 0, 1, 24'd0, 24'd0));
        end
        for (int t = 0; t < 5; t++) begin
            exp_a[t] = 24'd0;
            exp_b[t] = 24'd0;
        end
        run_seq("run_cleared", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the 3x3 systolic matrix multiplier (`top`).
- Holds operand matrices A and B, each 3x3 with 8-bit unsigned elements, loaded row by row through a valid/ready port.
- On `start`, drives the diagonally skewed operand streams on a1..a3 and b1..b3 that the array expects.
- Waits a fixed drain time for the array to finish accumulating, then pulses `done`.
- Also generates the accumulator-clear pulse for the array, so benches no longer hand-skew the inputs.

Parameters:
- DATA_W, 8: element width; a*/b* output width; load_data is 3*DATA_W.
- DRAIN_CYCLES, 8: zero-input cycles after the last stream cycle before `done`; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  row-write request.
- load_ready  out  1  high only in IDLE.
- load_sel  in  1  0 = write matrix A, 1 = write matrix B.
- load_row  in  2  row index 0..2; value 3 is accepted but writes nothing.
- load_data  in  3*DATA_W  [7:0]=col0, [15:8]=col1, [23:16]=col2.
- start  in  1  begin a feed sequence; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of the sequence.
- array_clr  out  1  one-cycle active-high clear for the array's `reset`.
- a1, a2, a3  out  DATA_W  row streams into the array.
- b1, b2, b3  out  DATA_W  column streams into the array.

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE; all A/B storage cleared to 0.
  - a*/b* = 0; busy = 0; done = 0; array_clr = 0; load_ready = 1 once reset deasserts.
- All outputs are registered.
- Load:
  - A write occurs on a clock edge with load_valid && load_ready.
  - The addressed row of A or B becomes load_data, per the byte map above.
  - Writes while busy are dropped (load_ready = 0).
- States: IDLE -> CLR -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - If start is sampled high: go to CLR.
  - A load in the same cycle as start is written first; the sequence uses the new data.
- CLR, 1 cycle: array_clr = 1; a*/b* = 0.
- STREAM, 5 cycles, t = 0..4, with outputs registered on the edge entering step t:
  - ai = A[i-1][t-(i-1)] when 0 <= t-(i-1) <= 2, else 0.
  - bj = B[t-(j-1)][j-1] when 0 <= t-(j-1) <= 2, else 0.
- DRAIN: a*/b* = 0 for DRAIN_CYCLES cycles, counted by an 8-bit counter.
- DONE: done = 1 for exactly 1 cycle, busy still high; next state is IDLE.
- start outside IDLE is ignored; there is no queueing.
- Latency: start sampled at edge E.
  - array_clr is high after E+1.
  - The first stream values appear after E+2; the last after E+6.
  - done is high after E+7+DRAIN_CYCLES.
- Matrix storage is unchanged by a run, so back-to-back runs reuse the same operands.
- Reset asserted mid-sequence:
  - Immediate return to IDLE with storage cleared.
  - No done pulse; array_clr drops to 0.

Test Plan:
- Load A rows {3,12,4},{5,6,8},{1,0,2} and B rows {7,3,8},{11,9,5},{6,8,4}, then start:
  - CLR: array_clr = 1, then outputs per STREAM step:
    - t0: a = (3,0,0), b = (7,0,0)
    - t1: a = (12,5,0), b = (11,3,0)
    - t2: a = (4,6,1), b = (6,9,8)
    - t3: a = (0,8,0), b = (0,8,5)
    - t4: a = (0,0,2), b = (0,0,4)
  - Then zeros.
  - done 15 cycles after the start edge, with DRAIN_CYCLES = 8.
- Same run with `top` downstream:
  - At done, c1..c9 = 177, 149, 100, 149, 133, 102, 19, 19, 16.
- start pulsed during STREAM and DRAIN:
  - Ignored; exactly one done pulse.
  - busy stays high throughout; no second array_clr.
- load_valid during busy with A row0 = {255,255,255}, followed by a rerun:
  - Stream still shows 3/12/4; load_ready = 0 while busy.
  - load_row = 3 in IDLE changes no stored value.
- Load A row0 = {9,9,9} in the same cycle as start:
  - t0 shows a1 = 9.
- reset driven low during STREAM t2:
  - All outputs are 0 asynchronously; no done pulse.
  - After reset release plus start, all a*/b* stay 0 (storage cleared).
